// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and helpers for the UART transmit serializer: state encoding,
// oversampling constants and the frame parity function.
package uart_tx_serializer_pkg;

   localparam int TX_OVERSAMPLE = 16;
   localparam int TX_TICK_BITS  = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_START   = 3'd3,
      ST_DATA    = 3'd4,
      ST_PARITY  = 3'd5,
      ST_STOP    = 3'd6
   } tx_state_t;

   // Parity over the bits that actually go on the line; bit 7 only counts in 8-bit mode.
   function automatic logic tx_parity(input logic [7:0] data,
                                      input logic       bit8,
                                      input logic       odd);
      logic p;
      p = ^data[6:0];
      if (bit8) p = p ^ data[7];
      return p ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Oversample counter for one serial bit: bit_end pulses on the OVERSAMPLE-th
// baud_en after the last clear.
module uart_tx_bit_timer
   import uart_tx_serializer_pkg::*;
#(
   parameter int OVERSAMPLE = TX_OVERSAMPLE,
   parameter int TICK_BITS  = TX_TICK_BITS
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic baud_en,
   output logic bit_end
);

   localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(OVERSAMPLE - 1);

   logic [TICK_BITS-1:0] tick_cnt;

   assign bit_end = baud_en && !clear && (tick_cnt == TICK_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (clear || bit_end) begin
         tick_cnt <= '0;
      end else if (baud_en) begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// Drains the TX FIFO one byte per frame and shifts it out on txd as
// start, 7/8 data bits LSB-first, optional parity and one stop bit.
module uart_tx_serializer
   import uart_tx_serializer_pkg::*;
#(
   parameter int FIFO_RD_LATENCY = 2,
   parameter int OVERSAMPLE      = TX_OVERSAMPLE,
   parameter int TICK_BITS       = TX_TICK_BITS
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       baud_en,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_read_n,
   output logic       txd,
   output logic       tx_busy
);

   localparam int WAIT_BITS = (FIFO_RD_LATENCY > 1) ? $clog2(FIFO_RD_LATENCY) : 1;
   localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(FIFO_RD_LATENCY - 1);

   tx_state_t            state;
   logic [WAIT_BITS-1:0] wait_cnt;
   logic [2:0]           bit_cnt;
   logic [7:0]           shift;
   logic                 cfg_bit8;
   logic                 cfg_parity_en;
   logic                 par_bit;
   logic                 timer_clear;
   logic                 bit_end;
   logic [2:0]           last_bit;

   // The bit timer only runs while a serial bit is on the line.
   assign timer_clear = (state == ST_IDLE) || (state == ST_RD_REQ) || (state == ST_RD_WAIT);
   assign last_bit    = cfg_bit8 ? 3'd7 : 3'd6;
   assign tx_busy     = (state != ST_IDLE);

   uart_tx_bit_timer #(
      .OVERSAMPLE (OVERSAMPLE),
      .TICK_BITS  (TICK_BITS)
   ) u_bit_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .baud_en (baud_en),
      .bit_end (bit_end)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         txd           <= 1'b1;
         fifo_read_n   <= 1'b1;
         wait_cnt      <= '0;
         bit_cnt       <= '0;
         shift         <= '0;
         cfg_bit8      <= 1'b0;
         cfg_parity_en <= 1'b0;
         par_bit       <= 1'b0;
      end else begin
         fifo_read_n <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state       <= ST_RD_REQ;
                  fifo_read_n <= 1'b0;
               end
            end
            ST_RD_REQ: begin
               state    <= ST_RD_WAIT;
               wait_cnt <= '0;
            end
            ST_RD_WAIT: begin
               // Data and line configuration are frozen here for the whole frame.
               if (wait_cnt == WAIT_LAST) begin
                  shift         <= fifo_data;
                  cfg_bit8      <= bit8;
                  cfg_parity_en <= parity_en;
                  par_bit       <= tx_parity(fifo_data, bit8, odd_n_even);
                  txd           <= 1'b0;
                  state         <= ST_START;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                  txd     <= shift[0];
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == last_bit) begin
                     if (cfg_parity_en) begin
                        state <= ST_PARITY;
                        txd   <= par_bit;
                     end else begin
                        state <= ST_STOP;
                        txd   <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shift   <= {1'b0, shift[7:1]};
                     txd     <= shift[1];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  state <= ST_STOP;
                  txd   <= 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_end) state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule
